// File: rtl/controle_magnetron_pkg.sv
// Shared definitions for the microwave magnetron controller: FSM state encoding,
// default timing parameters and a counter-width helper.
package controle_magnetron_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COOK  = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int unsigned TICK_DIV_DEFAULT    = 50_000_000;
  localparam int unsigned BEEP_CYCLES_DEFAULT = 150_000_000;

  // Width of a counter that runs 0..n-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/controle_magnetron_detector_borda.sv
// Registered falling-edge detector for an active-low push button.
// A button already held when reset lifts must be released once before it can fire.
module detector_borda (
  input  logic clk,
  input  logic reset,
  input  logic button,
  output logic fall
);

  logic cur;
  logic prev;
  logic armed;

  always_ff @(posedge clk) begin
    if (reset) begin
      cur   <= 1'b1;
      prev  <= 1'b1;
      armed <= 1'b0;
    end else begin
      cur   <= button;
      prev  <= cur;
      armed <= armed | button;
    end
  end

  // armed blocks the reset-to-1 history from turning a held button into an edge
  assign fall = armed & prev & ~cur;

endmodule

// File: rtl/controle_magnetron.sv
// Microwave timer control FSM: keypad entry, start/stop, door interlock,
// count tick generation and end-of-cycle alarm for the mm:ss down-counter.
module controle_magnetron
  import controle_magnetron_pkg::*;
#(
  parameter int unsigned TICK_DIV    = TICK_DIV_DEFAULT,
  parameter int unsigned BEEP_CYCLES = BEEP_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       startn,
  input  logic       stopn,
  input  logic       door_closed,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       cnt_zero,
  output logic [3:0] cnt_data,
  output logic       cnt_loadn,
  output logic       cnt_enablen,
  output logic       cnt_clearn,
  output logic       mag_on,
  output logic       alarm,
  output logic [1:0] state
);

  localparam int unsigned DW = cnt_width(TICK_DIV);
  localparam int unsigned BW = cnt_width(BEEP_CYCLES);
  localparam logic [DW-1:0] DIV_LAST  = DW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DIV_PRE   = DW'(TICK_DIV - 2);
  localparam logic [BW-1:0] BEEP_LAST = BW'(BEEP_CYCLES - 1);

  state_t        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [BW-1:0] beep_q, beep_d;
  logic [3:0]    data_d;
  logic          loadn_d, enablen_d, clearn_d;
  logic          start_fall, stop_fall;

  detector_borda u_start (
    .clk    (clk),
    .reset  (reset),
    .button (startn),
    .fall   (start_fall)
  );

  detector_borda u_stop (
    .clk    (clk),
    .reset  (reset),
    .button (stopn),
    .fall   (stop_fall)
  );

  always_comb begin
    state_d   = state_q;
    div_d     = '0;
    beep_d    = '0;
    data_d    = cnt_data;
    loadn_d   = 1'b1;
    enablen_d = 1'b1;
    clearn_d  = 1'b1;
    unique case (state_q)
      S_IDLE: begin
        if (key_valid && (key_code <= 4'd9)) begin
          data_d  = key_code;
          loadn_d = 1'b0;
        end
        if (stop_fall) begin
          clearn_d = 1'b0;
        end else if (start_fall && door_closed && !cnt_zero) begin
          state_d = S_COOK;
        end
      end
      S_COOK: begin
        if (!door_closed || stop_fall) begin
          state_d = S_PAUSE;
        end else if (cnt_zero) begin
          state_d = S_DONE;
        end else begin
          div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
          // registered strobe: decided one count early so it coincides with DIV_LAST
          enablen_d = (div_q != DIV_PRE);
        end
      end
      S_PAUSE: begin
        if (stop_fall) begin
          clearn_d = 1'b0;
          state_d  = S_IDLE;
        end else if (start_fall && door_closed) begin
          state_d = S_COOK;
        end
      end
      S_DONE: begin
        if (stop_fall || (beep_q == BEEP_LAST)) begin
          state_d = S_IDLE;
        end else begin
          beep_d = beep_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      div_q       <= '0;
      beep_q      <= '0;
      cnt_data    <= '0;
      cnt_loadn   <= 1'b1;
      cnt_enablen <= 1'b1;
      cnt_clearn  <= 1'b0;
      alarm       <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      beep_q      <= beep_d;
      cnt_data    <= data_d;
      cnt_loadn   <= loadn_d;
      cnt_enablen <= enablen_d;
      cnt_clearn  <= clearn_d;
      alarm       <= (state_d == S_DONE);
    end
  end

  assign mag_on = (state_q == S_COOK) && door_closed;
  assign state  = state_q;

endmodule
